posit_mul_issue: RTL and testbench

//  Operand issue stage directly upstream of the combinational posit multiplier
//  (Optimised_PM). Accepts operand pairs on a valid/ready handshake and buffers

---
 rtl/posit_mul_issue.sv | 134 +++++++++++++
 tb/tb_posit_mul_issue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mul_issue.sv
// Operand issue stage ahead of the combinational posit multiplier.
// A 2-entry FIFO decouples upstream ready from downstream ready. Each entry
// carries a zero/NaR classification so the multiplier can be bypassed.
module posit_mul_issue #(
  parameter int N  = 32,
  parameter int TW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_in1,
  input  logic [N-1:0]  s_in2,
  input  logic [TW-1:0] s_tag,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [N-1:0]  m_in1,
  output logic [N-1:0]  m_in2,
  output logic [TW-1:0] m_tag,
  output logic          m_special,
  output logic [N-1:0]  m_spec_res,
  output logic [CW-1:0] spec_cnt
);

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // Either operand NaR or zero makes the product trivially known.
  function automatic logic pair_special(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a == NAR) || (b == NAR) || (a == '0) || (b == '0);
  endfunction

  // NaR dominates zero; any other pair has no bypass result.
  function automatic logic [N-1:0] pair_result(input logic [N-1:0] a, input logic [N-1:0] b);
    return ((a == NAR) || (b == NAR)) ? NAR : '0;
  endfunction

  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [N-1:0]  in1_q [2];
  logic [N-1:0]  in1_d [2];
  logic [N-1:0]  in2_q [2];
  logic [N-1:0]  in2_d [2];
  logic [TW-1:0] tag_q [2];
  logic [TW-1:0] tag_d [2];
  logic          spc_q [2];
  logic          spc_d [2];
  logic [N-1:0]  res_q [2];
  logic [N-1:0]  res_d [2];
  logic [CW-1:0] spec_cnt_q, spec_cnt_d;

  logic push;
  logic pop;
  logic push_spc;

  assign s_ready  = (count_q != 2'd2);
  assign m_valid  = (count_q != 2'd0);
  assign push     = s_valid & s_ready;
  assign pop      = m_valid & m_ready;
  assign push_spc = pair_special(s_in1, s_in2);

  assign m_in1      = m_valid ? in1_q[rd_ptr_q] : '0;
  assign m_in2      = m_valid ? in2_q[rd_ptr_q] : '0;
  assign m_tag      = m_valid ? tag_q[rd_ptr_q] : '0;
  assign m_special  = m_valid ? spc_q[rd_ptr_q] : 1'b0;
  assign m_spec_res = m_valid ? res_q[rd_ptr_q] : '0;
  assign spec_cnt   = spec_cnt_q;

  // Next-state: flush wins over push/pop; otherwise write at wr_ptr, read at rd_ptr.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    tag_d      = tag_q;
    spc_d      = spc_q;
    res_d      = res_q;
    spec_cnt_d = spec_cnt_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        in1_d[wr_ptr_q] = s_in1;
        in2_d[wr_ptr_q] = s_in2;
        tag_d[wr_ptr_q] = s_tag;
        spc_d[wr_ptr_q] = push_spc;
        res_d[wr_ptr_q] = pair_result(s_in1, s_in2);
        wr_ptr_d        = ~wr_ptr_q;
        if (push_spc && (spec_cnt_q != {CW{1'b1}}))
          spec_cnt_d = spec_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      if (pop)
        rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; async reset clears control, entries and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      spec_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        in1_q[i] <= '0;
        in2_q[i] <= '0;
        tag_q[i] <= '0;
        spc_q[i] <= 1'b0;
        res_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      spec_cnt_q <= spec_cnt_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      tag_q      <= tag_d;
      spc_q      <= spc_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_posit_mul_issue.sv
// Scoreboard bench for posit_mul_issue: a queue-based reference model holds
// the expected FIFO contents; a negedge monitor compares every DUT output.
module tb_posit_mul_issue;
  localparam int N  = 32;
  localparam int TW = 4;
  localparam int CW = 4;
  localparam logic [N-1:0] NAR = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [N-1:0]  s_in1 = '0;
  logic [N-1:0]  s_in2 = '0;
  logic [TW-1:0] s_tag = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [N-1:0]  m_in1;
  logic [N-1:0]  m_in2;
  logic [TW-1:0] m_tag;
  logic          m_special;
  logic [N-1:0]  m_spec_res;
  logic [CW-1:0] spec_cnt;

  posit_mul_issue #(.N(N), .TW(TW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_in1(s_in1), .s_in2(s_in2), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_in1(m_in1), .m_in2(m_in2), .m_tag(m_tag),
    .m_special(m_special), .m_spec_res(m_spec_res), .spec_cnt(spec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [TW-1:0] tag;
    logic          sp;
    logic [N-1:0]  res;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;
  int   total = 0;
  int   bad = 0;

  // Expected entry straight from the classification rules.
  function automatic exp_t expect_of(logic [N-1:0] a, logic [N-1:0] b, logic [TW-1:0] t);
    exp_t e;
    e.a = a; e.b = b; e.tag = t;
    if (a == NAR || b == NAR) begin
      e.sp = 1'b1; e.res = NAR;
    end else if (a == 0 || b == 0) begin
      e.sp = 1'b1; e.res = 0;
    end else begin
      e.sp = 1'b0; e.res = 0;
    end
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model.
  always @(negedge clk) begin
    exp_t h;
    int   sz;
    if (!rst_n) begin
      q.delete();
      model_cnt = 0;
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_in1", 64'(m_in1), 64'd0);
      chk("rst_m_tag", 64'(m_tag), 64'd0);
      chk("rst_spec_cnt", 64'(spec_cnt), 64'd0);
    end else begin
      sz = q.size();
      chk("s_ready", 64'(s_ready), 64'(sz != 2));
      chk("m_valid", 64'(m_valid), 64'(sz != 0));
      chk("spec_cnt", 64'(spec_cnt), 64'(model_cnt));
      if (sz != 0) h = q[0];
      else h = '0;
      chk("m_in1", 64'(m_in1), 64'(h.a));
      chk("m_in2", 64'(m_in2), 64'(h.b));
      chk("m_tag", 64'(m_tag), 64'(h.tag));
      chk("m_special", 64'(m_special), 64'(h.sp));
      chk("m_spec_res", 64'(m_spec_res), 64'(h.res));
      if (flush) begin
        q.delete();
      end else begin
        if (sz != 0 && m_ready) void'(q.pop_front());
        if (s_valid && sz != 2) begin
          h = expect_of(s_in1, s_in2, s_tag);
          q.push_back(h);
          if (h.sp && model_cnt < (1 << CW) - 1) model_cnt++;
        end
      end
    end
  end

  // Offer one pair and hold it until accepted (bounded wait).
  task automatic send(logic [N-1:0] a, logic [N-1:0] b, logic [TW-1:0] t);
    bit ok = 0;
    s_valid = 1'b1; s_in1 = a; s_in2 = b; s_tag = t;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: s_ready=%0b expected 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return NAR;
      2: return 32'h4000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // single pair, one-cycle latency
    m_ready = 1'b1;
    send(32'h4000_0000, 32'h4000_0000, 4'd3);
    idle(3);

    // three back-to-back with stalled sink, released while third is held
    m_ready = 1'b0;
    fork
      begin
        send(32'h1111_1111, 32'h2222_2222, 4'd1);
        send(32'h3333_3333, 32'h4444_4444, 4'd2);
        send(32'h5555_5555, 32'h6666_6666, 4'd4);
      end
      begin
        idle(5);
        m_ready = 1'b1;
      end
    join
    idle(4);

    // full FIFO with simultaneous pop and offer
    m_ready = 1'b0;
    send(32'h0100_0000, 32'h0200_0000, 4'd5);
    send(32'h0300_0000, 32'h0400_0000, 4'd6);
    s_valid = 1'b1; s_in1 = 32'h0500_0000; s_in2 = 32'h0600_0000; s_tag = 4'd7;
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    idle(2);
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle(4);

    // special-case classification
    send(NAR, 32'h0, 4'd8);
    send(32'h0, 32'h0300_0000, 4'd9);
    send(32'h7FFF_FFFF, NAR, 4'd10);
    idle(3);

    // flush with two queued and a special pair offered
    m_ready = 1'b0;
    send(32'h1234_5678, 32'h0ABC_DEF0, 4'd11);
    send(32'h2345_6789, 32'h1BCD_EF01, 4'd12);
    s_valid = 1'b1; s_in1 = 32'h0; s_in2 = 32'h0; s_tag = 4'd13; flush = 1'b1;
    idle(1);
    flush = 1'b0; s_valid = 1'b0;
    idle(2);
    // flush with one queued, so the offered special pair would otherwise be taken
    send(32'h3456_789A, 32'h2CDE_F012, 4'd14);
    s_valid = 1'b1; s_in1 = NAR; s_in2 = 32'h1; s_tag = 4'd15; flush = 1'b1;
    idle(1);
    flush = 1'b0; s_valid = 1'b0;
    idle(2);

    // asynchronous reset mid-stream
    send(32'h4000_0000, 32'h0, 4'd2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", 64'(m_valid), 64'd0);
    chk("async_m_in1", 64'(m_in1), 64'd0);
    chk("async_m_special", 64'(m_special), 64'd0);
    chk("async_spec_cnt", 64'(spec_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // randomized traffic; counter saturates at 2^CW-1
    repeat (600) begin
      s_valid = $urandom_range(0, 1);
      s_in1 = pick(); s_in2 = pick(); s_tag = TW'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      idle(1);
    end
    chk("saturated", 64'(spec_cnt), 64'((1 << CW) - 1));

    s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
    idle(4);
    chk("drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
